// File: rtl/memory_dp_pkg.sv
// Shared types and constants for the dual-port init-capable memory.
package memory_dp_pkg;

    // Sequencer states: INIT clears the array, READY serves user traffic.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Supported read-latency range.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Address width for a given depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/memory_rd_pipe.sv
// Valid/data delay line for the read path. Data registers only load when
// the stage feeding them is valid, so the final stage holds its last value.
// A synchronous flush drops every in-flight valid without touching data.
module memory_rd_pipe #(
    parameter int STAGES = 1,
    parameter int W      = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data
);

    logic [STAGES-1:0] vld_p;
    logic [W-1:0]      data_p [STAGES];

    // Valid chain: shifts one stage per clock, cleared by reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (flush) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_vld;
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Data chain: a stage loads only behind a live valid, otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                data_p[i] <= '0;
            end
        end else if (!flush) begin
            if (in_vld) begin
                data_p[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (vld_p[i-1]) begin
                    data_p[i] <= data_p[i-1];
                end
            end
        end
    end

    assign out_vld  = vld_p[STAGES-1];
    assign out_data = data_p[STAGES-1];

endmodule

// File: rtl/memory_dp_init_ext.sv
// 1-write/1-read synchronous memory with a hardware init sequencer,
// configurable read latency and optional read-during-write bypass.
// Optional per-word even parity is enabled by defining MEMORY_DP_PARITY_EN.
module memory_dp_init_ext
    import memory_dp_pkg::*;
#(
    parameter int                    DEPTH      = 64,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    RD_LATENCY = 1,
    parameter bit                    BYPASS     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                   AW         = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  addr_err,
    output logic                  init_done,
    output logic                  rd_parity_err
);

    localparam int LAT = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam int PW = DATA_WIDTH + 1;

    state_t                state, state_nxt;
    logic [AW-1:0]         init_cnt, init_cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready;
    logic                  wr_acc, rd_acc;
    logic                  wr_oor, rd_oor;
    logic                  wr_hit, flush;
    logic [AW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_perr;
    logic                  pipe_vld;
    logic [PW-1:0]         pipe_out;

    assign ready  = (state == READY);
    assign wr_oor = 32'(wr_addr) >= 32'(DEPTH);
    assign rd_oor = 32'(rd_addr) >= 32'(DEPTH);

    // An init request wins over user traffic in the same cycle.
    assign wr_acc = ready && !init_req && wr_en;
    assign rd_acc = ready && !init_req && rd_en;
    assign flush  = !ready || init_req;
    assign wr_hit = wr_acc && !wr_oor && (wr_addr == rd_addr);
    assign rd_idx = rd_oor ? '0 : rd_addr;

    // State and init counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Sequencer: sweep every address once, restart on any init request.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            INIT: begin
                if (init_req) begin
                    init_cnt_nxt = '0;
                end else if (init_cnt == LAST) begin
                    state_nxt    = READY;
                    init_cnt_nxt = '0;
                end else begin
                    init_cnt_nxt = init_cnt + AW'(1);
                end
            end
            READY: begin
                if (init_req) begin
                    state_nxt    = INIT;
                    init_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = INIT;
                init_cnt_nxt = '0;
            end
        endcase
    end

    // Array write port: sequencer fill during INIT, user writes when READY.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[init_cnt] <= INIT_VALUE;
        end else if (wr_acc && !wr_oor) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read word selection: zero out of range, forwarded data on a bypassed hit.
    always_comb begin
        rd_word = mem[rd_idx];
        if (rd_oor) begin
            rd_word = '0;
        end else if (BYPASS && wr_hit) begin
            rd_word = wr_data;
        end
    end

`ifdef MEMORY_DP_PARITY_EN
    logic par_mem [DEPTH];

    // Parity write port, kept in lockstep with the data array.
    always_ff @(posedge clk) begin
        if (!ready) begin
            par_mem[init_cnt] <= ^INIT_VALUE;
        end else if (wr_acc && !wr_oor) begin
            par_mem[wr_addr] <= ^wr_data;
        end
    end

    // Forwarded data is fresh, so only array reads can carry a parity fault.
    assign rd_perr = !rd_oor && !(BYPASS && wr_hit) && ((^mem[rd_idx]) != par_mem[rd_idx]);
`else
    assign rd_perr = 1'b0;
`endif

    // Stage boundary: read result enters the latency pipeline.
    memory_rd_pipe #(
        .STAGES (LAT),
        .W      (PW)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (rd_acc),
        .in_data  ({rd_perr, rd_word}),
        .out_vld  (pipe_vld),
        .out_data (pipe_out)
    );

    // Out-of-range flag, one pulse per cycle regardless of how many ports missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (wr_acc && wr_oor) || (rd_acc && rd_oor);
        end
    end

    assign rd_valid      = pipe_vld;
    assign rd_data       = pipe_out[DATA_WIDTH-1:0];
    assign rd_parity_err = pipe_vld && pipe_out[DATA_WIDTH];
    assign init_done     = ready;

endmodule

// File: tb/tb_memory_dp_init_ext.sv
// Bench for memory_dp_init_ext: three instances (64/lat1/bypass,
// 48/lat2/no-bypass, 64/lat3/bypass) share one stimulus stream and are
// compared against a time-scheduled reference model.
module tb_memory_dp_init_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, init_req, wr_en, rd_en;
    logic [5:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;

    logic [31:0] data_o [3];
    logic        vld_o [3], aerr_o [3], done_o [3], perr_o [3];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int dep(input int k);
        return (k == 1) ? 48 : 64;
    endfunction
    function automatic int lat(input int k);
        return k + 1;
    endfunction
    function automatic bit byp(input int k);
        return k != 1;
    endfunction
    function automatic logic [31:0] ival(input int k);
        return (k == 2) ? 32'h0 : 32'hA5A5_A5A5;
    endfunction

    memory_dp_init_ext #(.DEPTH(64), .DATA_WIDTH(32), .RD_LATENCY(1), .BYPASS(1'b1), .INIT_VALUE(32'hA5A5_A5A5)) u0 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_o[0]), .rd_valid(vld_o[0]), .addr_err(aerr_o[0]),
        .init_done(done_o[0]), .rd_parity_err(perr_o[0]));
    memory_dp_init_ext #(.DEPTH(48), .DATA_WIDTH(32), .RD_LATENCY(2), .BYPASS(1'b0), .INIT_VALUE(32'hA5A5_A5A5)) u1 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_o[1]), .rd_valid(vld_o[1]), .addr_err(aerr_o[1]),
        .init_done(done_o[1]), .rd_parity_err(perr_o[1]));
    memory_dp_init_ext #(.DEPTH(64), .DATA_WIDTH(32), .RD_LATENCY(3), .BYPASS(1'b1), .INIT_VALUE(32'h0)) u2 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_o[2]), .rd_valid(vld_o[2]), .addr_err(aerr_o[2]),
        .init_done(done_o[2]), .rd_parity_err(perr_o[2]));

    // Reference model: word contents, a ready flag with a fill countdown,
    // and reads scheduled by the cycle number at which they must appear.
    logic [31:0] mm [3][64];
    bit          m_ready [3];
    int          m_cnt [3];
    bit          sv [3][8];
    logic [31:0] sd [3][8];
    bit          m_vld [3], m_aerr [3], m_done [3], aerr_n [3];
    logic [31:0] m_data [3];
    int          t;
    bit          ow, orr;
    logic [31:0] rv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0;
            for (int k = 0; k < 3; k++) begin
                m_ready[k] = 0; m_cnt[k] = 0; m_vld[k] = 0; m_data[k] = '0;
                m_aerr[k] = 0; m_done[k] = 0;
                for (int j = 0; j < 8; j++) sv[k][j] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                aerr_n[k] = 0;
                if (!m_ready[k]) begin
                    mm[k][m_cnt[k]] = ival(k);
                    if (init_req) m_cnt[k] = 0;
                    else if (m_cnt[k] == dep(k) - 1) m_ready[k] = 1;
                    else m_cnt[k] = m_cnt[k] + 1;
                end else if (init_req) begin
                    m_ready[k] = 0;
                    m_cnt[k]   = 0;
                    for (int j = 0; j < 8; j++) sv[k][j] = 0;
                end else begin
                    ow  = int'(wr_addr) >= dep(k);
                    orr = int'(rd_addr) >= dep(k);
                    if (rd_en) begin
                        if (orr) rv = 32'h0;
                        else if (byp(k) && wr_en && !ow && wr_addr == rd_addr) rv = wr_data;
                        else rv = mm[k][rd_addr];
                        sv[k][(t + lat(k)) % 8] = 1;
                        sd[k][(t + lat(k)) % 8] = rv;
                    end
                    if (wr_en && !ow) mm[k][wr_addr] = wr_data;
                    aerr_n[k] = (wr_en && ow) || (rd_en && orr);
                end
            end
            t = t + 1;
            for (int k = 0; k < 3; k++) begin
                m_vld[k] = sv[k][t % 8];
                if (sv[k][t % 8]) m_data[k] = sd[k][t % 8];
                sv[k][t % 8] = 0;
                m_aerr[k] = aerr_n[k];
                m_done[k] = m_ready[k];
            end
        end
    end

    task automatic idle();
        init_req = 0; wr_en = 0; rd_en = 0;
    endtask

    task automatic test_reset();
        int first [3];
        rst_n = 0; idle(); wr_addr = 0; rd_addr = 0; wr_data = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({vld_o[k], aerr_o[k], done_o[k], perr_o[k]} !== 4'b0 || data_o[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_values u%0d: got vld=%b aerr=%b done=%b perr=%b data=%h, want all 0",
                         k, vld_o[k], aerr_o[k], done_o[k], perr_o[k], data_o[k]);
            end
            first[k] = -1;
        end
        rst_n = 1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (vld_o[k] !== m_vld[k] || data_o[k] !== m_data[k] || aerr_o[k] !== m_aerr[k] ||
                    done_o[k] !== m_done[k] || perr_o[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL model_reset u%0d t=%0d: got vld=%b data=%h aerr=%b done=%b perr=%b, want vld=%b data=%h aerr=%b done=%b perr=0",
                             k, t, vld_o[k], data_o[k], aerr_o[k], done_o[k], perr_o[k], m_vld[k], m_data[k], m_aerr[k], m_done[k]);
                end
                if (done_o[k] === 1'b1 && first[k] < 0) first[k] = c;
            end
            if (vld_o[0] === 1'b1) begin
                n_cmp++;
                if (data_o[0] !== 32'hA5A5_A5A5) begin
                    n_fail++;
                    $display("FAIL init_value u0: got %h want a5a5a5a5", data_o[0]);
                end
            end
            idle();
            if (c >= 70 && c < 73) begin
                rd_en   = 1;
                rd_addr = (c == 70) ? 6'd0 : (c == 71) ? 6'd31 : 6'd63;
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (first[k] !== dep(k)) begin
                n_fail++;
                $display("FAIL init_time u%0d: got %0d cycles want %0d", k, first[k], dep(k));
            end
        end
    endtask

    task automatic test_latency();
        int seen [3] = '{0, 0, 0};
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (vld_o[k] !== m_vld[k] || data_o[k] !== m_data[k] || aerr_o[k] !== m_aerr[k] ||
                    done_o[k] !== m_done[k] || perr_o[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL model_latency u%0d t=%0d: got vld=%b data=%h aerr=%b done=%b, want vld=%b data=%h aerr=%b done=%b",
                             k, t, vld_o[k], data_o[k], aerr_o[k], done_o[k], m_vld[k], m_data[k], m_aerr[k], m_done[k]);
                end
                if (vld_o[k] === 1'b1) begin
                    n_cmp++;
                    if (c - 8 - lat(k) !== seen[k] || data_o[k] !== 32'(3 * seen[k])) begin
                        n_fail++;
                        $display("FAIL latency u%0d: got data=%h at slot %0d, want data=%h at slot %0d",
                                 k, data_o[k], c - 8 - lat(k), 32'(3 * seen[k]), seen[k]);
                    end
                    seen[k]++;
                end
            end
            idle();
            if (c < 8) begin
                wr_en = 1; wr_addr = 6'(c); wr_data = 32'(3 * c);
            end else if (c < 16) begin
                rd_en = 1; rd_addr = 6'(c - 8);
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (seen[k] !== 8) begin
                n_fail++;
                $display("FAIL latency_count u%0d: got %0d valids want 8", k, seen[k]);
            end
        end
    endtask

    task automatic test_collision();
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (vld_o[k] !== m_vld[k] || data_o[k] !== m_data[k] || aerr_o[k] !== m_aerr[k] ||
                    done_o[k] !== m_done[k] || perr_o[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL model_collision u%0d t=%0d: got vld=%b data=%h, want vld=%b data=%h",
                             k, t, vld_o[k], data_o[k], m_vld[k], m_data[k]);
                end
                if (c == 5) begin
                    n_cmp++;
                    if (data_o[k] !== (byp(k) ? 32'h1234 : 32'hFFFF)) begin
                        n_fail++;
                        $display("FAIL collision u%0d: got %h want %h", k, data_o[k], byp(k) ? 32'h1234 : 32'hFFFF);
                    end
                end
                if (c == 10) begin
                    n_cmp++;
                    if (data_o[k] !== 32'h1234) begin
                        n_fail++;
                        $display("FAIL collision_stored u%0d: got %h want 00001234", k, data_o[k]);
                    end
                end
            end
            idle();
            if (c == 0) begin
                wr_en = 1; wr_addr = 6'd5; wr_data = 32'hFFFF;
            end else if (c == 1) begin
                wr_en = 1; wr_addr = 6'd5; wr_data = 32'h1234; rd_en = 1; rd_addr = 6'd5;
            end else if (c == 5) begin
                rd_en = 1; rd_addr = 6'd5;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (vld_o[k] !== m_vld[k] || data_o[k] !== m_data[k] || aerr_o[k] !== m_aerr[k] ||
                    done_o[k] !== m_done[k] || perr_o[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL model_random u%0d t=%0d: got vld=%b data=%h aerr=%b done=%b, want vld=%b data=%h aerr=%b done=%b",
                             k, t, vld_o[k], data_o[k], aerr_o[k], done_o[k], m_vld[k], m_data[k], m_aerr[k], m_done[k]);
                end
            end
            idle();
            if (c < 395) begin
                wr_en   = 1'($urandom_range(0, 1));
                rd_en   = 1'($urandom_range(0, 1));
                wr_data = $urandom;
                wr_addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
                rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 6'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) rd_addr = 6'($urandom_range(48, 63));
            end
        end
    endtask

    task automatic test_reinit();
        int seen [3] = '{0, 0, 0};
        int low [3]  = '{0, 0, 0};
        int late [3] = '{0, 0, 0};
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (vld_o[k] !== m_vld[k] || data_o[k] !== m_data[k] || aerr_o[k] !== m_aerr[k] ||
                    done_o[k] !== m_done[k] || perr_o[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL model_reinit u%0d t=%0d: got vld=%b data=%h aerr=%b done=%b, want vld=%b data=%h aerr=%b done=%b",
                             k, t, vld_o[k], data_o[k], aerr_o[k], done_o[k], m_vld[k], m_data[k], m_aerr[k], m_done[k]);
                end
                if (c >= 4 && c < 75 && done_o[k] === 1'b0) low[k]++;
                if (c >= 4 && c < 75 && vld_o[k] === 1'b1) late[k]++;
                if (c >= 75 && vld_o[k] === 1'b1) begin
                    n_cmp++;
                    if (data_o[k] !== ((seen[k] < dep(k)) ? ival(k) : 32'h0)) begin
                        n_fail++;
                        $display("FAIL reinit_contents u%0d addr %0d: got %h want %h",
                                 k, seen[k], data_o[k], (seen[k] < dep(k)) ? ival(k) : 32'h0);
                    end
                    seen[k]++;
                end
            end
            idle();
            if (c < 3) begin
                rd_en = 1; rd_addr = 6'(c + 20);
            end else if (c == 3) begin
                init_req = 1;
            end else if (c >= 75 && c < 139) begin
                rd_en = 1; rd_addr = 6'(c - 75);
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (low[k] !== dep(k) || late[k] !== 0 || seen[k] !== 64) begin
                n_fail++;
                $display("FAIL reinit u%0d: got low=%0d killed_leak=%0d reads=%0d, want low=%0d leak=0 reads=64",
                         k, low[k], late[k], seen[k], dep(k));
            end
        end
    endtask

    task automatic test_restart();
        int first [3] = '{-1, -1, -1};
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (vld_o[k] !== m_vld[k] || data_o[k] !== m_data[k] || aerr_o[k] !== m_aerr[k] ||
                    done_o[k] !== m_done[k] || perr_o[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL model_restart u%0d t=%0d: got vld=%b done=%b, want vld=%b done=%b",
                             k, t, vld_o[k], done_o[k], m_vld[k], m_done[k]);
                end
                if (c > 10 && done_o[k] === 1'b1 && first[k] < 0) first[k] = c;
            end
            idle();
            if (c == 0 || c == 10) init_req = 1;
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (first[k] !== 11 + dep(k)) begin
                n_fail++;
                $display("FAIL restart_time u%0d: got %0d want %0d", k, first[k], 11 + dep(k));
            end
        end
    endtask

    task automatic test_oor();
        int pulses [3] = '{0, 0, 0};
        int seen       = 0;
        for (int c = 0; c < 58; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (vld_o[k] !== m_vld[k] || data_o[k] !== m_data[k] || aerr_o[k] !== m_aerr[k] ||
                    done_o[k] !== m_done[k] || perr_o[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL model_oor u%0d t=%0d: got vld=%b data=%h aerr=%b, want vld=%b data=%h aerr=%b",
                             k, t, vld_o[k], data_o[k], aerr_o[k], m_vld[k], m_data[k], m_aerr[k]);
                end
                if (aerr_o[k] === 1'b1) pulses[k]++;
            end
            if (vld_o[1] === 1'b1) begin
                n_cmp++;
                if (data_o[1] !== ((seen < 2) ? 32'h0 : 32'hA5A5_A5A5)) begin
                    n_fail++;
                    $display("FAIL oor_read u1 slot %0d: got %h want %h", seen, data_o[1],
                             (seen < 2) ? 32'h0 : 32'hA5A5_A5A5);
                end
                seen++;
            end
            idle();
            if (c == 0) begin
                wr_en = 1; wr_addr = 6'd50; wr_data = 32'hDEAD_BEEF;
            end else if (c == 1) begin
                rd_en = 1; rd_addr = 6'd50;
            end else if (c == 2) begin
                wr_en = 1; wr_addr = 6'd60; wr_data = 32'h0BAD_F00D; rd_en = 1; rd_addr = 6'd60;
            end else if (c < 51) begin
                rd_en = 1; rd_addr = 6'(c - 3);
            end
        end
        n_cmp++;
        if (pulses[1] !== 3 || pulses[0] !== 0 || pulses[2] !== 0 || seen !== 50) begin
            n_fail++;
            $display("FAIL oor_pulses: got u0=%0d u1=%0d u2=%0d reads=%0d, want 0 3 0 reads=50",
                     pulses[0], pulses[1], pulses[2], seen);
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle();
            rd_en = 1; rd_addr = 6'($urandom_range(0, 15));
        end
        #2 rst_n = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({vld_o[k], aerr_o[k], done_o[k], perr_o[k]} !== 4'b0 || data_o[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL async_reset u%0d: got vld=%b aerr=%b done=%b data=%h, want all 0",
                         k, vld_o[k], aerr_o[k], done_o[k], data_o[k]);
            end
        end
        @(negedge clk);
        idle();
        rst_n = 1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (vld_o[k] !== m_vld[k] || data_o[k] !== m_data[k] || aerr_o[k] !== m_aerr[k] ||
                    done_o[k] !== m_done[k] || perr_o[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL model_async u%0d t=%0d: got vld=%b done=%b, want vld=%b done=%b",
                             k, t, vld_o[k], done_o[k], m_vld[k], m_done[k]);
                end
            end
        end
    endtask

`ifdef MEMORY_DP_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        u0.mem[9] = u0.mem[9] ^ 32'h1;
        idle(); rd_en = 1; rd_addr = 6'd9;
        @(negedge clk);
        n_cmp++;
        if (vld_o[0] !== 1'b1 || perr_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_flip u0: got vld=%b perr=%b want 1 1", vld_o[0], perr_o[0]);
        end
        rd_addr = 6'd10;
        @(negedge clk);
        n_cmp++;
        if (vld_o[0] !== 1'b1 || perr_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_clean u0: got vld=%b perr=%b want 1 0", vld_o[0], perr_o[0]);
        end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_collision();
        test_random();
        test_reinit();
        test_restart();
        test_oor();
        test_async_reset();
`ifdef MEMORY_DP_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
